display_channel_scheduler: RTL and testbench
============================================

Name: display_channel_scheduler

Overview:
- Shares the single three-digit seven-segment readout between N_CH 8-bit telemetry channels, such as pitch, roll and yaw error magnitudes.
- Rotates round-robin over valid channels and holds each one on the display for a dwell period.
- Converts the selected binary value to three BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Drives the per-digit seven-segment encoders directly. Decimal carry is computed in 8 cycles, replacing count-up-to-value schemes whose latency grows with the value.

Parameters:
- N_CH, 3, number of requesting channels (2..8).
- DWELL_CYCLES, 50_000_000, clk cycles each channel stays displayed after publish (≥2).
- CH_W, derived localparam $clog2(N_CH), width of channel index (min 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_val  in  8*N_CH  packed channel values; channel k at [8k+7:8k].
- ch_valid  in  N_CH  channel k participates in rotation when 1.
- hold  in  1  freezes dwell counter (stays on current channel).
- force_sel  in  1  override: display force_ch only.
- force_ch  in  CH_W  channel shown while force_sel=1.
- bcd_ones  out  4  ones digit.
- bcd_tens  out  4  tens digit.
- bcd_hund  out  4  hundreds digit (0..2).
- ch_id  out  CH_W  channel whose value is on bcd_*.
- disp_valid  out  1  bcd_*/ch_id hold a published conversion.
- update  out  1  one-cycle pulse when new digits are published.
- busy  out  1  high in CONVERT and PUBLISH.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=SELECT; rr pointer=N_CH-1 so channel 0 is checked first; dwell counter=0.
- FSM states: SELECT, CONVERT, PUBLISH, DWELL.
- SELECT:
  - force_sel=1: pick force_ch; valid bit ignored; rr pointer unchanged.
  - Otherwise: pick the first channel with ch_valid=1 scanning ptr+1, ptr+2, … modulo N_CH.
  - Nothing selectable: remain in SELECT; outputs keep their last values; update=0.
  - On a pick: latch value into an 8-bit shift register, clear the 12-bit BCD accumulator, record pending channel, update rr pointer (non-forced picks only), go to CONVERT.
  - force_ch ≥ N_CH: treated as channel 0.
- CONVERT, exactly 8 cycles (iteration counter 0..7), each cycle:
  - Add 3 to each BCD nibble ≥5.
  - Shift {bcd, bin} left by 1.
  - ch_val changes during CONVERT are ignored.
- PUBLISH, 1 cycle:
  - Register bcd_* and ch_id; set disp_valid=1; pulse update=1.
  - Clear dwell counter; go to DWELL.
- Latency: SELECT pick at cycle t → update high at t+9 → bcd_* valid from t+10.
- DWELL:
  - Increment counter each cycle unless hold=1 (frozen).
  - Leave to SELECT when counter=DWELL_CYCLES-1 and hold=0.
  - Abort to SELECT next cycle if force_sel=1 and force_ch≠ch_id.
  - Abort to SELECT next cycle on a force_sel 1→0 transition (rotation resumes).
  - Re-selecting the same channel re-converts it, so changed values refresh once per dwell.
- Simultaneous events: force abort beats hold. hold has no effect outside DWELL.
- Single valid channel: that channel re-converts every DWELL_CYCLES+10 cycles.
- Reset mid-CONVERT: conversion discarded; outputs 0.
- Arithmetic: 255 max → bcd_hund ≤2. No overflow path. All counters are unsigned and wrap is impossible by construction.

Decomposition:
- Shared package disp_pkg holds:
  - state enum {SELECT, CONVERT, PUBLISH, DWELL};
  - BCD_DIGITS=3;
  - VAL_W=8;
  - the digit nibble typedef.
- One sub-module, bin2bcd_seq: the start/done iterative double-dabble engine (8-bit in, 12-bit out, 8-cycle latency). The scheduler owns selection, dwell and publishing.
- The existing single-digit seven-segment encoder consumes bcd_*.

Test Plan:
- Reset, ch_valid=3'b001, ch0=255 → update at cycle 9 after first SELECT; bcd_hund/tens/ones=2/5/5, ch_id=0, disp_valid=1.
- ch0=0, ch1=100, ch2=9, all valid, DWELL_CYCLES=4 → published sequence ch0 {0,0,0}, ch1 {1,0,0}, ch2 {0,0,9}, ch0…; update pulses 14 cycles apart.
- ch_valid=3'b101 → rotation 0,2,0,2; ch1 never published. ch_valid=0 after reset → disp_valid stays 0, no update.
- hold=1 for 20 cycles during DWELL → next update delayed by exactly 20 cycles. force_sel=1, force_ch=1 mid-DWELL on ch0 → SELECT next cycle; ch1 published 10 cycles later; persists while forced; release resumes rotation at ch1's successor.
- ch0 changes 37→199 during CONVERT → published 0/3/7. The next dwell publishes 1/9/9.
- rst_n low at CONVERT iteration 4 → all outputs 0 immediately. After release, first publish is channel 0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display channel scheduler and its
// binary-to-BCD engine.
package disp_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int VAL_W      = 8;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    SELECT,
    CONVERT,
    PUBLISH,
    DWELL
  } state_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next shift, so pre-add 3 to carry it into the next digit.
  function automatic digit_t add3_if_ge5(input digit_t d);
    return (d >= 4'd5) ? digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter: one start pulse loads an 8-bit value,
// the result sits on dout from the cycle after done until the next start.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VAL_W-1:0]        din,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] dout
);

  localparam int ITER_W = $clog2(VAL_W);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);

  logic                    running;
  logic [ITER_W-1:0]       iter;
  logic [VAL_W-1:0]        bin_sr;
  logic [4*BCD_DIGITS-1:0] bcd_acc;
  logic [4*BCD_DIGITS-1:0] bcd_adj;

  // Apply the add-3 correction to every digit before the shift.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      bcd_adj[4*d +: 4] = add3_if_ge5(bcd_acc[4*d +: 4]);
    end
  end

  // Iteration control: exactly VAL_W shift steps after each start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      iter    <= '0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= '0;
    end else if (running) begin
      iter <= iter + 1'b1;
      if (iter == ITER_LAST) running <= 1'b0;
    end
  end

  // Datapath: load on start, then shift {bcd, bin} left one bit per step.
  always_ff @(posedge clk) begin
    if (start) begin
      bin_sr  <= din;
      bcd_acc <= '0;
    end else if (running) begin
      bcd_acc <= {bcd_adj[4*BCD_DIGITS-2:0], bin_sr[VAL_W-1]};
      bin_sr  <= {bin_sr[VAL_W-2:0], 1'b0};
    end
  end

  assign done = running && (iter == ITER_LAST);
  assign dout = bcd_acc;

endmodule

// File: rtl/display_channel_scheduler.sv
// Time-shares one three-digit readout between N_CH telemetry channels:
// round-robin selection over valid channels, sequential BCD conversion,
// publish, then hold the digits for a dwell period.
module display_channel_scheduler
  import disp_pkg::*;
#(
  parameter  int N_CH         = 3,
  parameter  int DWELL_CYCLES = 50_000_000,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VAL_W*N_CH-1:0] ch_val,
  input  logic [N_CH-1:0]       ch_valid,
  input  logic                  hold,
  input  logic                  force_sel,
  input  logic [CH_W-1:0]       force_ch,
  output logic [3:0]            bcd_ones,
  output logic [3:0]            bcd_tens,
  output logic [3:0]            bcd_hund,
  output logic [CH_W-1:0]       ch_id,
  output logic                  disp_valid,
  output logic                  update,
  output logic                  busy
);

  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  state_t                  state;
  logic [CH_W-1:0]         rr_ptr;
  logic [CH_W-1:0]         pend_ch;
  logic [DW_W-1:0]         dwell_cnt;
  logic                    force_q;

  logic [CH_W-1:0]         force_eff;
  logic [CH_W-1:0]         scan_idx;
  logic [CH_W-1:0]         pick_ch;
  logic                    pick_ok;
  logic [VAL_W-1:0]        sel_val;
  logic                    conv_start;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic                    force_abort;

  // Choose the next channel: forced channel wins, otherwise the first valid
  // channel after the round-robin pointer. Out-of-range force maps to 0.
  always_comb begin
    force_eff = (int'(force_ch) < N_CH) ? force_ch : '0;
    pick_ok   = 1'b0;
    pick_ch   = '0;
    scan_idx  = '0;
    if (force_sel) begin
      pick_ok = 1'b1;
      pick_ch = force_eff;
    end else begin
      for (int i = 1; i <= N_CH; i++) begin
        scan_idx = CH_W'((int'(rr_ptr) + i) % N_CH);
        if (!pick_ok && ch_valid[scan_idx]) begin
          pick_ok = 1'b1;
          pick_ch = scan_idx;
        end
      end
    end
  end

  assign sel_val    = ch_val[int'(pick_ch)*VAL_W +: VAL_W];
  assign conv_start = (state == SELECT) && pick_ok;

  // Leave DWELL early when a different channel is forced, or when forcing
  // is released so rotation resumes straight away.
  assign force_abort = (force_sel && (force_eff != ch_id)) || (force_q && !force_sel);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .din   (sel_val),
    .done  (conv_done),
    .dout  (conv_bcd)
  );

  // Scheduler FSM with registered outputs; update is raised on entry to
  // PUBLISH and the digits themselves are registered during PUBLISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SELECT;
      rr_ptr     <= CH_W'(N_CH - 1);
      pend_ch    <= '0;
      dwell_cnt  <= '0;
      force_q    <= 1'b0;
      bcd_ones   <= '0;
      bcd_tens   <= '0;
      bcd_hund   <= '0;
      ch_id      <= '0;
      disp_valid <= 1'b0;
      update     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      force_q <= force_sel;
      update  <= 1'b0;
      case (state)
        SELECT: begin
          if (pick_ok) begin
            pend_ch <= pick_ch;
            if (!force_sel) rr_ptr <= pick_ch;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            update <= 1'b1;
            state  <= PUBLISH;
          end
        end
        PUBLISH: begin
          bcd_ones   <= conv_bcd[0 +: 4];
          bcd_tens   <= conv_bcd[4 +: 4];
          bcd_hund   <= conv_bcd[8 +: 4];
          ch_id      <= pend_ch;
          disp_valid <= 1'b1;
          dwell_cnt  <= '0;
          busy       <= 1'b0;
          state      <= DWELL;
        end
        DWELL: begin
          if (force_abort) begin
            state <= SELECT;
          end else if (!hold) begin
            if (dwell_cnt == DW_LAST) state <= SELECT;
            else dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_display_channel_scheduler.sv
// Directed-plus-random bench for display_channel_scheduler with N_CH=3 and
// a short dwell. Expected channel order, publish spacing and decimal digits
// are derived from the rotation rules and plain integer arithmetic.
module tb_display_channel_scheduler;

  localparam int N_CH  = 3;
  localparam int DWELL = 4;
  localparam int CH_W  = 2;
  localparam int PERIOD_GAP = DWELL + 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [8*N_CH-1:0] ch_val;
  logic [N_CH-1:0]   ch_valid;
  logic              hold;
  logic              force_sel;
  logic [CH_W-1:0]   force_ch;
  logic [3:0]        bcd_ones, bcd_tens, bcd_hund;
  logic [CH_W-1:0]   ch_id;
  logic              disp_valid, update, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int m_ptr = N_CH - 1;
  int upd_total = 0;

  display_channel_scheduler #(.N_CH(N_CH), .DWELL_CYCLES(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_val     (ch_val),
    .ch_valid   (ch_valid),
    .hold       (hold),
    .force_sel  (force_sel),
    .force_ch   (force_ch),
    .bcd_ones   (bcd_ones),
    .bcd_tens   (bcd_tens),
    .bcd_hund   (bcd_hund),
    .ch_id      (ch_id),
    .disp_valid (disp_valid),
    .update     (update),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (update === 1'b1) upd_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rotation rule: first valid channel after pointer p, modulo N_CH.
  function automatic int next_ch(input logic [N_CH-1:0] v, input int p);
    for (int i = 1; i <= N_CH; i++) begin
      if (v[(p + i) % N_CH]) return (p + i) % N_CH;
    end
    return -1;
  endfunction

  function automatic int chv(input int k);
    return int'(ch_val[8*k +: 8]);
  endfunction

  // Wait for the next update pulse and check spacing, channel and digits.
  // Returns one cycle after the pulse, i.e. in the first dwell cycle.
  task automatic expect_publish(input string tag, input int exp_ch, input int exp_val,
                                input int exp_gap);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (update === 1'b1) seen = 1'b1;
    end
    check($sformatf("%s_update_seen", tag), seen, 1);
    if (seen) begin
      check($sformatf("%s_gap", tag), cyc - ref_cyc, exp_gap);
      check($sformatf("%s_busy", tag), busy, 1);
      ref_cyc = cyc;
      @(negedge clk);
      check($sformatf("%s_pulse_len", tag), update, 0);
      check($sformatf("%s_ch_id", tag), ch_id, exp_ch);
      check($sformatf("%s_hund", tag), bcd_hund, exp_val / 100);
      check($sformatf("%s_tens", tag), bcd_tens, (exp_val / 10) % 10);
      check($sformatf("%s_ones", tag), bcd_ones, exp_val % 10);
      check($sformatf("%s_disp_valid", tag), disp_valid, 1);
    end
  endtask

  task automatic rotate(input string tag, input int n, input bit rnd);
    int e;
    for (int k = 0; k < n; k++) begin
      e = next_ch(ch_valid, m_ptr);
      m_ptr = e;
      expect_publish(tag, e, chv(e), PERIOD_GAP);
      if (rnd) ch_val = (8*N_CH)'($urandom);
    end
  endtask

  task automatic wait_busy(input string tag);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_hund", tag), bcd_hund, 0);
    check($sformatf("%s_tens", tag), bcd_tens, 0);
    check($sformatf("%s_ones", tag), bcd_ones, 0);
    check($sformatf("%s_ch_id", tag), ch_id, 0);
    check($sformatf("%s_disp_valid", tag), disp_valid, 0);
    check($sformatf("%s_update", tag), update, 0);
    check($sformatf("%s_busy", tag), busy, 0);
  endtask

  initial begin
    int e;
    int v;
    rst_n     = 1'b0;
    ch_val    = '0;
    ch_valid  = '0;
    hold      = 1'b0;
    force_sel = 1'b0;
    force_ch  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // No valid channel: nothing is ever published.
    rst_n = 1'b1;
    m_ptr = N_CH - 1;
    repeat (30) @(negedge clk);
    check("idle_disp_valid", disp_valid, 0);
    check("idle_updates", upd_total, 0);
    check("idle_busy", busy, 0);

    // Single channel at full scale, then random values on the same channel.
    ch_val[7:0] = 8'd255;
    ch_valid    = 3'b001;
    ref_cyc     = cyc;
    m_ptr       = next_ch(ch_valid, m_ptr);
    expect_publish("first", 0, 255, 9);
    for (int k = 0; k < 3; k++) begin
      v = int'($urandom_range(0, 255));
      ch_val[7:0] = 8'(v);
      expect_publish("single", 0, v, PERIOD_GAP);
    end

    // All three channels valid, fixed then random values.
    ch_val   = {8'd9, 8'd100, 8'd0};
    ch_valid = 3'b111;
    rotate("rot3", 3, 1'b0);
    rotate("rot3r", 4, 1'b1);

    // Channel 1 excluded from rotation.
    ch_valid = 3'b101;
    rotate("rot2", 4, 1'b1);

    // Hold for 20 cycles stretches the dwell by exactly 20.
    hold = 1'b1;
    repeat (20) @(negedge clk);
    hold = 1'b0;
    e = next_ch(ch_valid, m_ptr);
    m_ptr = e;
    expect_publish("hold", e, chv(e), PERIOD_GAP + 20);

    // Get channel 0 on the display before forcing.
    for (int k = 0; k < 2; k++) begin
      if (m_ptr != 0) rotate("align", 1, 1'b0);
    end
    check("align_ch0", ch_id, 0);

    // Force channel 1 mid-dwell, keep it, then release.
    force_sel = 1'b1;
    force_ch  = 2'd1;
    ref_cyc   = cyc;
    expect_publish("force", 1, chv(1), 10);
    expect_publish("force_keep", 1, chv(1), PERIOD_GAP);
    force_sel = 1'b0;
    ref_cyc   = cyc;
    e = next_ch(ch_valid, m_ptr);
    m_ptr = e;
    expect_publish("release", e, chv(e), 10);

    // Out-of-range forced channel behaves as channel 0.
    force_sel = 1'b1;
    force_ch  = 2'd3;
    ref_cyc   = cyc;
    expect_publish("force_oor", 0, chv(0), 10);
    force_sel = 1'b0;
    ref_cyc   = cyc;
    e = next_ch(ch_valid, m_ptr);
    m_ptr = e;
    expect_publish("release2", e, chv(e), 10);

    // Value change during conversion is not seen until the next dwell.
    ch_valid    = 3'b001;
    ch_val[7:0] = 8'd37;
    wait_busy("cvt_busy_seen");
    repeat (2) @(negedge clk);
    ch_val[7:0] = 8'd199;
    m_ptr = 0;
    expect_publish("cvt_old", 0, 37, PERIOD_GAP);
    expect_publish("cvt_new", 0, 199, PERIOD_GAP);

    // Reset in the middle of a conversion clears everything at once.
    wait_busy("rst_busy_seen");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n    = 1'b1;
    ch_valid = 3'b111;
    ch_val   = (8*N_CH)'($urandom);
    m_ptr    = N_CH - 1;
    e = next_ch(ch_valid, m_ptr);
    m_ptr = e;
    ref_cyc = cyc;
    expect_publish("post_rst", e, chv(e), 9);
    rotate("post_rot", 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
